vga_timing_monitor: RTL and testbench

//  Receive end of the Tetris VGA output: samples hsync/vsync/r/g/b produced in the clk6_25 domain and measures the timing.

---
 rtl/vga_timing_monitor_pkg.sv | 29 ++
 rtl/vga_timing_monitor_seg7_scanner.sv | 48 ++++
 rtl/vga_timing_monitor.sv | 219 +++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_monitor_pkg.sv
// rtl/vga_timing_monitor_pkg.sv - shared types, segment table and helpers for the VGA timing monitor
package vga_timing_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    MEASURE    = 2'd1,
    LOCKED     = 2'd2
  } mon_state_t;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0-F, dp off
  localparam logic [7:0] SEG7_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // True when value lies within expected +/- tol; widened by one bit so the sums cannot wrap
  function automatic logic within_tol(input logic [11:0] value,
                                      input logic [11:0] expected,
                                      input logic [11:0] tol);
    logic [12:0] v;
    logic [12:0] e;
    logic [12:0] t;
    v = {1'b0, value};
    e = {1'b0, expected};
    t = {1'b0, tol};
    return ((v + t) >= e) && (v <= (e + t));
  endfunction

endpackage

// File: rtl/vga_timing_monitor_seg7_scanner.sv
// rtl/vga_timing_monitor_seg7_scanner.sv - 4-digit multiplexed hex 7-segment driver
module seg7_scanner
  import vga_timing_monitor_pkg::*;
#(
  parameter int SCAN_BITS = 16
) (
  input  logic        clk100,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        dp_en,
  output logic [3:0]  display_sel,
  output logic [7:0]  display
);

  logic [SCAN_BITS-1:0] scan_ctr;
  logic [1:0]           digit;
  logic [3:0]           nibble;
  logic                 dp_on;

  assign digit = scan_ctr[SCAN_BITS-1 -: 2];
  assign dp_on = dp_en && (digit == 2'd0);

  // Pick the nibble belonging to the digit currently being scanned
  always_comb begin
    nibble = value[3:0];
    case (digit)
      2'd0: nibble = value[3:0];
      2'd1: nibble = value[7:4];
      2'd2: nibble = value[11:8];
      2'd3: nibble = value[15:12];
      default: nibble = value[3:0];
    endcase
  end

  // Free-running scan counter and registered segment/enable outputs
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      scan_ctr    <= '0;
      display_sel <= 4'hF;
      display     <= 8'hFF;
    end else begin
      scan_ctr    <= scan_ctr + 1'b1;
      display_sel <= ~(4'b0001 << digit);
      display     <= SEG7_HEX[nibble] & {~dp_on, 7'h7F};
    end
  end

endmodule

// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - measures looped-back VGA timing, reports lock and drives the 7-seg display
module vga_timing_monitor
  import vga_timing_monitor_pkg::*;
#(
  parameter int EXP_LINE_CYC    = 2080,
  parameter int EXP_HSYNC_CYC   = 240,
  parameter int EXP_LINES       = 666,
  parameter int EXP_VSYNC_LINES = 6,
  parameter int TOL             = 4,
  parameter int SCAN_BITS       = 16
) (
  input  logic        clk100,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  rgb_in,
  input  logic [1:0]  sel,
  output logic [11:0] line_cycles,
  output logic [11:0] hsync_cycles,
  output logic [9:0]  frame_lines,
  output logic [3:0]  vsync_lines,
  output logic [9:0]  lit_lines,
  output logic        frame_strobe,
  output logic        locked,
  output logic [3:0]  display_sel,
  output logic [7:0]  display
);

  localparam logic [11:0] CYC_MAX  = 12'hFFF;
  localparam logic [9:0]  LINE_MAX = 10'h3FF;
  localparam logic [3:0]  VS_MAX   = 4'hF;

  logic       hs_s1, hs_s2, hs_d;
  logic       vs_s1, vs_s2, vs_d;
  logic [2:0] rgb_s1, rgb_s2;
  logic       hs_fall, hs_rise, vs_fall, rgb_any;

  logic [11:0] cyc_ctr, line_shadow;
  logic [11:0] hs_ctr, hs_shadow;
  logic [9:0]  line_ctr, lit_ctr;
  logic [3:0]  vs_ctr;
  logic        line_lit;
  logic        vs_inc, lit_inc;

  mon_state_t state_q, state_d;
  logic [1:0] good_ctr, good_d;
  logic       locked_d, publish, timeout, frame_good;
  logic [15:0] disp_value;

  // Sync chains idle high on the active-low syncs so reset never fakes an edge
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      hs_s1  <= 1'b1; hs_s2 <= 1'b1; hs_d <= 1'b1;
      vs_s1  <= 1'b1; vs_s2 <= 1'b1; vs_d <= 1'b1;
      rgb_s1 <= 3'b000;
      rgb_s2 <= 3'b000;
    end else begin
      hs_s1  <= hsync_in; hs_s2 <= hs_s1; hs_d <= hs_s2;
      vs_s1  <= vsync_in; vs_s2 <= vs_s1; vs_d <= vs_s2;
      rgb_s1 <= rgb_in;
      rgb_s2 <= rgb_s1;
    end
  end

  assign hs_fall = hs_d & ~hs_s2;
  assign hs_rise = ~hs_d & hs_s2;
  assign vs_fall = vs_d & ~vs_s2;
  assign rgb_any = |rgb_s2;
  assign vs_inc  = hs_fall & ~vs_s2;
  assign lit_inc = hs_fall & line_lit;

  // Line/hsync timers with shadows, plus per-frame line counters cleared at vsync fall
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      cyc_ctr     <= '0;
      line_shadow <= '0;
      hs_ctr      <= '0;
      hs_shadow   <= '0;
      line_ctr    <= '0;
      vs_ctr      <= '0;
      lit_ctr     <= '0;
      line_lit    <= 1'b0;
    end else begin
      if (hs_fall) begin
        line_shadow <= cyc_ctr;
        cyc_ctr     <= 12'd1;
      end else if (cyc_ctr != CYC_MAX) begin
        cyc_ctr <= cyc_ctr + 12'd1;
      end

      if (hs_rise) begin
        hs_shadow <= hs_ctr;
        hs_ctr    <= '0;
      end else if (!hs_s2 && (hs_ctr != CYC_MAX)) begin
        hs_ctr <= hs_ctr + 12'd1;
      end

      if (hs_fall)      line_lit <= 1'b0;
      else if (rgb_any) line_lit <= 1'b1;

      // A hsync fall coincident with vsync fall belongs to the new frame
      if (vs_fall) begin
        line_ctr <= {9'd0, hs_fall};
        vs_ctr   <= {3'd0, vs_inc};
        lit_ctr  <= {9'd0, lit_inc};
      end else begin
        if (hs_fall && (line_ctr != LINE_MAX)) line_ctr <= line_ctr + 10'd1;
        if (vs_inc  && (vs_ctr   != VS_MAX))   vs_ctr   <= vs_ctr + 4'd1;
        if (lit_inc && (lit_ctr  != LINE_MAX)) lit_ctr  <= lit_ctr + 10'd1;
      end
    end
  end

  assign timeout    = (cyc_ctr == CYC_MAX) || (line_ctr == LINE_MAX);
  assign frame_good = within_tol(line_shadow, 12'(EXP_LINE_CYC), 12'(TOL)) &&
                      within_tol(hs_shadow, 12'(EXP_HSYNC_CYC), 12'(TOL)) &&
                      (line_ctr == 10'(EXP_LINES)) &&
                      (vs_ctr == 4'(EXP_VSYNC_LINES));

  // Lock FSM: decides when to publish and how the good-frame streak moves
  always_comb begin
    state_d  = state_q;
    good_d   = good_ctr;
    locked_d = locked;
    publish  = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        if (vs_fall) state_d = MEASURE;
      end
      MEASURE: begin
        if (timeout) begin
          state_d  = WAIT_FRAME;
          good_d   = 2'd0;
          locked_d = 1'b0;
        end else if (vs_fall) begin
          publish = 1'b1;
          if (frame_good) begin
            good_d = good_ctr + 2'd1;
            if (good_ctr == 2'd1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_d = 2'd0;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_d  = WAIT_FRAME;
          good_d   = 2'd0;
          locked_d = 1'b0;
        end else if (vs_fall) begin
          publish = 1'b1;
          if (!frame_good) begin
            state_d  = MEASURE;
            good_d   = 2'd0;
            locked_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = WAIT_FRAME;
        good_d   = 2'd0;
        locked_d = 1'b0;
      end
    endcase
  end

  // FSM state, lock flag and published measurement registers
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state_q      <= WAIT_FRAME;
      good_ctr     <= 2'd0;
      locked       <= 1'b0;
      frame_strobe <= 1'b0;
      line_cycles  <= '0;
      hsync_cycles <= '0;
      frame_lines  <= '0;
      vsync_lines  <= '0;
      lit_lines    <= '0;
    end else begin
      state_q      <= state_d;
      good_ctr     <= good_d;
      locked       <= locked_d;
      frame_strobe <= publish;
      if (publish) begin
        line_cycles  <= line_shadow;
        hsync_cycles <= hs_shadow;
        frame_lines  <= line_ctr;
        vsync_lines  <= vs_ctr;
        lit_lines    <= lit_ctr;
      end
    end
  end

  // Measurement routed to the display, zero-extended to four hex digits
  always_comb begin
    disp_value = 16'h0000;
    case (sel)
      2'd0:    disp_value = {4'h0, line_cycles};
      2'd1:    disp_value = {4'h0, hsync_cycles};
      2'd2:    disp_value = {6'h00, frame_lines};
      default: disp_value = {6'h00, lit_lines};
    endcase
  end

  seg7_scanner #(
    .SCAN_BITS(SCAN_BITS)
  ) u_seg7_scanner (
    .clk100      (clk100),
    .reset_n     (reset_n),
    .value       (disp_value),
    .dp_en       (locked),
    .display_sel (display_sel),
    .display     (display)
  );

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb/tb_vga_timing_monitor.sv - scoreboard bench for vga_timing_monitor with a scaled VGA source
module tb_vga_timing_monitor;

  localparam int L   = 80;
  localparam int HS  = 12;
  localparam int NL  = 20;
  localparam int VS  = 3;
  localparam int TOL = 4;
  localparam int SB  = 6;

  logic        clk100 = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [2:0]  rgb_in = 3'b000;
  logic [1:0]  sel = 2'd0;
  logic [11:0] line_cycles, hsync_cycles;
  logic [9:0]  frame_lines, lit_lines;
  logic [3:0]  vsync_lines, display_sel;
  logic        frame_strobe, locked;
  logic [7:0]  display;

  always #5 clk100 = ~clk100;

  vga_timing_monitor #(
    .EXP_LINE_CYC(L), .EXP_HSYNC_CYC(HS), .EXP_LINES(NL),
    .EXP_VSYNC_LINES(VS), .TOL(TOL), .SCAN_BITS(SB)
  ) dut (
    .clk100(clk100), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .sel(sel), .line_cycles(line_cycles), .hsync_cycles(hsync_cycles),
    .frame_lines(frame_lines), .vsync_lines(vsync_lines), .lit_lines(lit_lines),
    .frame_strobe(frame_strobe), .locked(locked), .display_sel(display_sel), .display(display)
  );

  typedef struct {
    int line;
    int hs;
    int fl;
    int vl;
    int lit;
    int lk;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int tick = 0;
  int m_state = 0;
  int m_good = 0;
  int p_len = 0;
  int p_lit = 0;
  logic [3:0] sel_pat [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always @(posedge clk100) tick <= tick + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_line_cycles", int'(line_cycles), 0);
    check("rst_hsync_cycles", int'(hsync_cycles), 0);
    check("rst_frame_lines", int'(frame_lines), 0);
    check("rst_vsync_lines", int'(vsync_lines), 0);
    check("rst_lit_lines", int'(lit_lines), 0);
    check("rst_frame_strobe", int'(frame_strobe), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_display_sel", int'(display_sel), 15);
    check("rst_display", int'(display), 255);
  endtask

  // Monitor: every strobe must match the oldest expected publish
  initial begin
    exp_t e;
    forever begin
      @(negedge clk100);
      if (frame_strobe) begin
        if (sbq.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("sb_line_cycles", int'(line_cycles), e.line);
          check("sb_hsync_cycles", int'(hsync_cycles), e.hs);
          check("sb_frame_lines", int'(frame_lines), e.fl);
          check("sb_vsync_lines", int'(vsync_lines), e.vl);
          check("sb_lit_lines", int'(lit_lines), e.lit);
          check("sb_locked", int'(locked), e.lk);
        end
      end
    end
  end

  task automatic drive_line(input int len, input bit vs_low, input bit lit);
    for (int c = 0; c < len; c++) begin
      @(negedge clk100);
      hsync_in = (c >= HS);
      vsync_in = !vs_low;
      rgb_in   = (lit && c >= 20 && c < 60) ? 3'b111 : 3'b000;
    end
  endtask

  // One frame of uniform line length; its start is the vsync fall that publishes the previous frame
  task automatic frame(input int len, input int lf, input int ll, input int rst_line);
    exp_t e;
    bit good;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      good = (p_len >= L - TOL) && (p_len <= L + TOL);
      if (good) begin
        m_good = (m_good < 2) ? m_good + 1 : 2;
        if (m_good == 2) m_state = 2;
      end else begin
        m_good  = 0;
        m_state = 1;
      end
      e.line = p_len; e.hs = HS; e.fl = NL; e.vl = VS; e.lit = p_lit;
      e.lk = (m_state == 2) ? 1 : 0;
      sbq.push_back(e);
    end
    p_len = len;
    p_lit = (ll >= lf) ? ll - lf + 1 : 0;
    for (int l = 0; l < NL; l++) begin
      if (l == rst_line) begin
        @(negedge clk100);
        reset_n = 1'b0;
        @(negedge clk100);
        reset_n = 1'b1;
        check_reset_outputs();
        m_state = 0;
        m_good  = 0;
      end
      drive_line(len, l < VS, l >= lf && l <= ll);
    end
  endtask

  task automatic wait_digit(input int d);
    int n;
    n = 0;
    while (display_sel != sel_pat[d] && n < 200) begin
      @(negedge clk100);
      n++;
    end
    check("digit_select", int'(display_sel), int'(sel_pat[d]));
  endtask

  // Hsync parked high: display readout while still locked, then the line timeout
  task automatic hold_and_display();
    int t0;
    t0 = tick;
    sel = 2'd2;
    repeat (3) @(negedge clk100);
    wait_digit(0); check("disp_fl_d0", int'(display), 8'h19);
    wait_digit(1); check("disp_fl_d1", int'(display), 8'hF9);
    wait_digit(2); check("disp_fl_d2", int'(display), 8'hC0);
    wait_digit(3); check("disp_fl_d3", int'(display), 8'hC0);
    sel = 2'd0;
    repeat (3) @(negedge clk100);
    wait_digit(1); check("disp_lc_d1", int'(display), 8'h92);
    wait_digit(0); check("disp_lc_d0", int'(display), 8'h40);
    while (tick - t0 < 3000) @(negedge clk100);
    check("hold_locked_early", int'(locked), 1);
    while (tick - t0 < 5000) @(negedge clk100);
    check("timeout_locked", int'(locked), 0);
    check("timeout_line_cycles", int'(line_cycles), 80);
    check("timeout_hsync_cycles", int'(hsync_cycles), 12);
    check("timeout_frame_lines", int'(frame_lines), 20);
    check("timeout_lit_lines", int'(lit_lines), 3);
    m_state = 0;
    m_good  = 0;
  endtask

  initial begin
    repeat (100000) @(posedge clk100);
    $display("FAIL watchdog cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk100);
    check_reset_outputs();
    reset_n = 1'b1;
    repeat (20) @(negedge clk100);

    repeat (4) frame(80, 5, 14, -1);
    check("locked_after_third_pub", int'(locked), 1);
    frame(83, 5, 14, -1);
    frame(85, 5, 14, -1);
    frame(80, 5, 14, -1);
    frame(80, 5, 7, -1);
    frame(80, 5, 14, -1);

    hold_and_display();

    frame(80, 5, 14, -1);
    frame(80, 5, 14, -1);
    frame(80, 5, 14, -1);
    frame(80, 5, 14, 10);
    frame(80, 5, 14, -1);
    frame(80, 5, 14, -1);
    frame(80, 5, 14, -1);
    frame(80, 5, 14, -1);

    repeat (20) @(negedge clk100);
    check("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
